// File: rtl/mod241_chunk_if.sv
// mod241_chunk_if: chunk-in / residue-out handshake bundle; out_zero exists only with MOD241_ZERO_FLAG_EN
interface mod241_chunk_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_chunk;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_residue;
  logic       out_err;
`ifdef MOD241_ZERO_FLAG_EN
  logic       out_zero;
  modport master (output in_valid, in_chunk, in_last, out_ready,
                  input  in_ready, out_valid, out_residue, out_err, out_zero);
  modport slave  (input  in_valid, in_chunk, in_last, out_ready,
                  output in_ready, out_valid, out_residue, out_err, out_zero);
`else
  modport master (output in_valid, in_chunk, in_last, out_ready,
                  input  in_ready, out_valid, out_residue, out_err);
  modport slave  (input  in_valid, in_chunk, in_last, out_ready,
                  output in_ready, out_valid, out_residue, out_err);
`endif
endinterface

// File: rtl/mod241_serial_reducer.sv
// mod241_serial_reducer: Horner reduction of an MSB-first 6-bit chunk stream modulo 241.
// Optional MOD241_ZERO_FLAG_EN adds a registered residue==0 flag (out_zero).
module mod241_serial_reducer #(
  parameter int NUM_CHUNKS = 84
) (
  input  logic          clk,
  input  logic          rst,
  mod241_chunk_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [13:0] wide;
  logic [10:0] fold1;
  logic [8:0]  fold2;
  logic [7:0]  acc_red;
  logic [9:0]  cnt_inc;
  logic        accept, full;
`ifdef MOD241_ZERO_FLAG_EN
  logic        zero_q, zero_d;
`endif
  // 256 == 15 (mod 241): two folds bring 15423 down below 2*241, then one conditional subtract
  assign wide    = {acc_q, 6'b0} + 14'(bus.in_chunk);
  assign fold1   = 11'(wide[13:8]) * 11'd15 + 11'(wide[7:0]);
  assign fold2   = 9'(fold1[10:8]) * 9'd15 + 9'(fold1[7:0]);
  assign acc_red = fold2 >= 9'd241 ? 8'(fold2 - 9'd241) : fold2[7:0];
  assign cnt_inc = cnt_q + 10'd1;
  assign full    = cnt_inc == 10'(NUM_CHUNKS);
  assign accept  = bus.in_valid & bus.in_ready;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef MOD241_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    if (state_q == DONE) begin
      if (bus.out_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
`ifdef MOD241_ZERO_FLAG_EN
        zero_d  = 1'b0;
`endif
      end
    end else if (accept) begin
      acc_d   = acc_red;
      cnt_d   = cnt_inc;
      err_d   = bus.in_last ^ full;
      state_d = (bus.in_last | full) ? DONE : ACCUM;
`ifdef MOD241_ZERO_FLAG_EN
      zero_d  = (bus.in_last | full) & (acc_red == 8'd0);
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MOD241_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MOD241_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end
  assign bus.in_ready    = state_q != DONE;
  assign bus.out_valid   = state_q == DONE;
  assign bus.out_residue = acc_q;
  assign bus.out_err     = err_q;
`ifdef MOD241_ZERO_FLAG_EN
  assign bus.out_zero    = zero_q;
`endif
endmodule

// File: tb/tb_mod241_serial_reducer.sv
// tb_mod241_serial_reducer: scoreboard bench for the mod-241 chunk reducer (84-chunk and 2-chunk builds)
module tb_mod241_serial_reducer;
  localparam int N = 84;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  bit bp_rand = 1'b0;
  bit ready_lvl = 1'b1;
  logic [5:0] chunks [0:1023];
  logic [8:0] exp_q [$];
  mod241_chunk_if bus ();
  mod241_chunk_if b2 ();
  mod241_serial_reducer #(.NUM_CHUNKS(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  mod241_serial_reducer #(.NUM_CHUNKS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send_op(input int n, input bit with_last, input bit gaps, input bit push, input int exp_res);
    int acc;
    int guard;
    acc = 0;
    for (int i = 0; i < n; i++) acc = (acc * 64 + int'(chunks[i])) % 241;
    if (push) exp_q.push_back({with_last ? (n != N) : 1'b1, exp_res >= 0 ? 8'(exp_res) : 8'(acc)});
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_chunk = chunks[i];
      bus.in_last  = with_last && (i == n - 1);
      guard = 0;
      while (!bus.in_ready && guard < 300) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 300) begin
        check("in_ready timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", int'(exp_q.size()), 0);
  endtask
  task automatic load_255(input logic [5:0] last_chunk);
    for (int i = 0; i < 82; i++) chunks[i] = 6'd0;
    chunks[82] = 6'd3;
    chunks[83] = last_chunk;
  endtask
  initial forever begin
    @(posedge clk); #1;
    bus.out_ready = bp_rand ? ($urandom_range(3) != 0) : ready_lvl;
  end
  initial forever begin
    @(negedge clk);
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected residue", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("residue", int'(bus.out_residue), int'(e[7:0]));
        check("err", int'(bus.out_err), int'(e[8]));
`ifdef MOD241_ZERO_FLAG_EN
        check("zero", int'(bus.out_zero), int'(e[7:0] == 8'd0));
`endif
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0; bus.in_chunk = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_chunk = '0; b2.in_last = 1'b0; b2.out_ready = 1'b1;
    #12;
    check("rst in_ready", int'(bus.in_ready), 1);
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst residue", int'(bus.out_residue), 0);
    check("rst err", int'(bus.out_err), 0);
`ifdef MOD241_ZERO_FLAG_EN
    check("rst zero", int'(bus.out_zero), 0);
`endif
    #10 rst = 1'b0;
    @(posedge clk); #1;
    // 241 -> residue 0, plus latency: valid right after the last accept
    load_255(6'd49);
    send_op(N, 1'b1, 1'b0, 1'b1, 0);
    check("latency valid", int'(bus.out_valid), 1);
    drain();
    // 255 -> 14 held under back-pressure
    ready_lvl = 1'b0;
    @(posedge clk); #1;
    load_255(6'd63);
    send_op(N, 1'b1, 1'b0, 1'b1, 14);
    for (int k = 0; k < 5; k++) begin
      check("hold valid", int'(bus.out_valid), 1);
      check("hold in_ready", int'(bus.in_ready), 0);
      check("hold residue", int'(bus.out_residue), 14);
      check("hold err", int'(bus.out_err), 0);
      @(posedge clk); #1;
    end
    ready_lvl = 1'b1;
    drain();
    // all ones: 2^504 - 1 == 0 mod 241
    for (int i = 0; i < N; i++) chunks[i] = 6'd63;
    send_op(N, 1'b1, 1'b0, 1'b1, 0);
    drain();
    // framing: early last on chunk 10, then 84 chunks with no last
    for (int i = 0; i < N; i++) chunks[i] = 6'($urandom_range(63));
    send_op(10, 1'b1, 1'b0, 1'b1, -1);
    drain();
    send_op(N, 1'b0, 1'b0, 1'b1, -1);
    check("forced done", int'(bus.out_valid), 1);
    drain();
    // two-chunk build: 63,63 -> 4095 mod 241 = 239
    b2.in_valid = 1'b1; b2.in_chunk = 6'd63; b2.in_last = 1'b0;
    @(posedge clk); #1;
    b2.in_last = 1'b1;
    @(posedge clk); #1;
    b2.in_valid = 1'b0; b2.in_last = 1'b0;
    check("n2 valid", int'(b2.out_valid), 1);
    check("n2 residue", int'(b2.out_residue), 239);
    check("n2 err", int'(b2.out_err), 0);
    // random operands with gaps and back-pressure
    bp_rand = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      int r;
      r = int'($urandom_range(3));
      for (int i = 0; i < N; i++) chunks[i] = 6'($urandom_range(63));
      if (r == 0) send_op(N, 1'b1, 1'b1, 1'b1, -1);
      else if (r == 1) send_op(N, 1'b0, 1'b1, 1'b1, -1);
      else send_op(int'($urandom_range(20, 1)), 1'b1, 1'b1, 1'b1, -1);
    end
    bp_rand = 1'b0;
    drain();
    // asynchronous reset mid-operand, then a clean 255 operand
    for (int i = 0; i < N; i++) chunks[i] = 6'd17;
    send_op(40, 1'b0, 1'b0, 1'b0, -1);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready", int'(bus.in_ready), 1);
    check("midrst valid", int'(bus.out_valid), 0);
    check("midrst residue", int'(bus.out_residue), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    load_255(6'd63);
    send_op(N, 1'b1, 1'b0, 1'b1, 14);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
